// File: rtl/mesi_pkg.sv
// Shared encodings for the L2 MESI line controller: line states, snoop results,
// command opcodes, bus operations and the controller FSM states.
package mesi_pkg;

    typedef enum logic [1:0] {
        ST_M = 2'b00,
        ST_E = 2'b01,
        ST_S = 2'b10,
        ST_I = 2'b11
    } mesi_state_e;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'b00,
        SNP_HIT   = 2'b01,
        SNP_HITM  = 2'b10
    } snoop_res_e;

    typedef enum logic [1:0] {
        BUS_READ       = 2'd0,
        BUS_RFO        = 2'd1,
        BUS_INVALIDATE = 2'd2
    } bus_op_e;

    localparam logic [3:0] OP_L1_READ  = 4'd0;
    localparam logic [3:0] OP_L1_WRITE = 4'd1;
    localparam logic [3:0] OP_L1_IREAD = 4'd2;
    localparam logic [3:0] OP_SNP_INV  = 4'd3;
    localparam logic [3:0] OP_SNP_READ = 4'd4;
    localparam logic [3:0] OP_SNP_WRITE = 4'd5;
    localparam logic [3:0] OP_SNP_RFO  = 4'd6;
    localparam logic [3:0] OP_CLEAR    = 4'd8;
    localparam logic [3:0] OP_PRINT    = 4'd9;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_LOOKUP,
        FSM_BUS,
        FSM_UPDATE,
        FSM_CLEAR
    } fsm_state_e;

    function automatic logic is_l1_read(input logic [3:0] op);
        return (op == OP_L1_READ) || (op == OP_L1_IREAD);
    endfunction

endpackage

// File: rtl/mesi_next_state.sv
// Combinational MESI transition table: (current state, opcode, bus snoop result)
// to next state, snoop response, writeback flag and required bus operation.
// Error output exists only when MESI_PROTOCOL_ERR_EN is defined.
module mesi_next_state
    import mesi_pkg::*;
(
    input  logic [1:0] i_state,
    input  logic [3:0] i_op,
    input  logic [1:0] i_snoop_res,
    output logic [1:0] o_next,
    output logic [1:0] o_snoop,
    output logic       o_wb,
    output logic       o_bus_req,
    output logic [1:0] o_bus_op
`ifdef MESI_PROTOCOL_ERR_EN
   ,output logic       o_err
`endif
);

    always_comb begin
        o_next    = i_state;
        o_snoop   = SNP_NOHIT;
        o_wb      = 1'b0;
        o_bus_req = 1'b0;
        o_bus_op  = BUS_READ;
        if (is_l1_read(i_op)) begin
            if (i_state == ST_I) begin
                o_bus_req = 1'b1;
                o_bus_op  = BUS_READ;
                o_next    = (i_snoop_res == SNP_HIT || i_snoop_res == SNP_HITM) ? ST_S : ST_E;
            end
        end else begin
            case (i_op)
                OP_L1_WRITE: begin
                    o_next = ST_M;
                    if (i_state == ST_S) begin
                        o_bus_req = 1'b1;
                        o_bus_op  = BUS_INVALIDATE;
                    end else if (i_state == ST_I) begin
                        o_bus_req = 1'b1;
                        o_bus_op  = BUS_RFO;
                    end
                end
                OP_SNP_READ, OP_SNP_RFO: begin
                    if (i_state != ST_I) begin
                        o_next  = (i_op == OP_SNP_READ) ? ST_S : ST_I;
                        o_snoop = (i_state == ST_M) ? SNP_HITM : SNP_HIT;
                        o_wb    = (i_state == ST_M);
                    end
                end
                // Invalidate only acts on shared copies; M/E stay put as protocol errors.
                OP_SNP_INV: begin
                    if (i_state == ST_S) begin
                        o_next  = ST_I;
                        o_snoop = SNP_HIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MESI_PROTOCOL_ERR_EN
    always_comb begin
        o_err = 1'b0;
        case (i_op)
            OP_L1_READ, OP_L1_WRITE, OP_L1_IREAD,
            OP_SNP_READ, OP_SNP_RFO, OP_CLEAR, OP_PRINT: o_err = 1'b0;
            OP_SNP_INV:   o_err = (i_state == ST_M) || (i_state == ST_E);
            OP_SNP_WRITE: o_err = (i_state != ST_I);
            default:      o_err = 1'b1;
        endcase
    end
`endif

endmodule

// File: rtl/mesi_line_ctrl.sv
// Sequential MESI controller holding the state of every L2 line; one command at
// a time. Define MESI_PROTOCOL_ERR_EN to add the err_sticky / err_count outputs.
module mesi_line_ctrl
    import mesi_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    localparam int SET_W = $clog2(NUM_SETS),
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [SET_W-1:0] cmd_set,
    input  logic [WAY_W-1:0] cmd_way,
    output logic             bus_req_valid,
    output logic [1:0]       bus_req_op,
    input  logic             bus_ack,
    input  logic [1:0]       bus_snoop_res,
    output logic             rsp_valid,
    output logic [1:0]       rsp_prev_state,
    output logic [1:0]       rsp_next_state,
    output logic [1:0]       rsp_snoop_out,
    output logic             rsp_writeback,
    output logic             busy
`ifdef MESI_PROTOCOL_ERR_EN
   ,output logic             err_sticky,
    output logic [7:0]       err_count
`endif
);

    fsm_state_e       r_state, w_state_nxt;
    logic [1:0]       r_lines [NUM_SETS][NUM_WAYS];
    logic [3:0]       r_op;
    logic [SET_W-1:0] r_set;
    logic [WAY_W-1:0] r_way;
    logic [SET_W-1:0] r_clr_set;
    logic [1:0]       r_prev, r_next, r_snoop, r_bus_op;
    logic             r_wb;

    logic [1:0]       w_cur, w_next, w_snoop, w_bus_op;
    logic             w_wb, w_bus_req;
    logic             w_clr_last;

    assign w_cur      = r_lines[r_set][r_way];
    assign w_clr_last = (r_clr_set == SET_W'(NUM_SETS - 1));

`ifdef MESI_PROTOCOL_ERR_EN
    logic w_err;
`endif

    mesi_next_state u_next_state (
        .i_state     (w_cur),
        .i_op        (r_op),
        .i_snoop_res (bus_snoop_res),
        .o_next      (w_next),
        .o_snoop     (w_snoop),
        .o_wb        (w_wb),
        .o_bus_req   (w_bus_req),
        .o_bus_op    (w_bus_op)
`ifdef MESI_PROTOCOL_ERR_EN
       ,.o_err       (w_err)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FSM_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        bus_req_valid  = 1'b0;
        bus_req_op     = BUS_READ;
        rsp_valid      = 1'b0;
        rsp_prev_state = ST_I;
        rsp_next_state = ST_I;
        rsp_snoop_out  = SNP_NOHIT;
        rsp_writeback  = 1'b0;
        case (r_state)
            FSM_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) w_state_nxt = (cmd_op == OP_CLEAR) ? FSM_CLEAR : FSM_LOOKUP;
            end
            FSM_LOOKUP: w_state_nxt = w_bus_req ? FSM_BUS : FSM_UPDATE;
            FSM_BUS: begin
                bus_req_valid = 1'b1;
                bus_req_op    = r_bus_op;
                if (bus_ack) w_state_nxt = FSM_UPDATE;
            end
            FSM_CLEAR: if (w_clr_last) w_state_nxt = FSM_UPDATE;
            FSM_UPDATE: begin
                rsp_valid      = 1'b1;
                rsp_prev_state = r_prev;
                rsp_next_state = r_next;
                rsp_snoop_out  = r_snoop;
                rsp_writeback  = r_wb;
                w_state_nxt    = FSM_IDLE;
            end
            default: w_state_nxt = FSM_IDLE;
        endcase
    end

    // Response fields are latched in LOOKUP and overwritten on the bus ack, so
    // misses resolve their final state from the returned snoop result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 4'd0;
            r_set     <= '0;
            r_way     <= '0;
            r_clr_set <= '0;
            r_prev    <= ST_I;
            r_next    <= ST_I;
            r_snoop   <= SNP_NOHIT;
            r_wb      <= 1'b0;
            r_bus_op  <= BUS_READ;
        end else begin
            case (r_state)
                FSM_IDLE: begin
                    if (cmd_valid) begin
                        r_op      <= cmd_op;
                        r_set     <= cmd_set;
                        r_way     <= cmd_way;
                        r_clr_set <= '0;
                    end
                end
                FSM_LOOKUP: begin
                    r_prev   <= w_cur;
                    r_next   <= w_next;
                    r_snoop  <= w_snoop;
                    r_wb     <= w_wb;
                    r_bus_op <= w_bus_op;
                end
                FSM_BUS: begin
                    if (bus_ack) begin
                        r_next  <= w_next;
                        r_snoop <= w_snoop;
                        r_wb    <= w_wb;
                    end
                end
                FSM_CLEAR: begin
                    r_clr_set <= r_clr_set + 1'b1;
                    r_prev    <= ST_I;
                    r_next    <= ST_I;
                    r_snoop   <= SNP_NOHIT;
                    r_wb      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++)
                    r_lines[s][w] <= ST_I;
        end else if (r_state == FSM_CLEAR) begin
            for (int w = 0; w < NUM_WAYS; w++)
                r_lines[r_clr_set][w] <= ST_I;
        end else if (r_state == FSM_UPDATE) begin
            r_lines[r_set][r_way] <= r_next;
        end
    end

`ifdef MESI_PROTOCOL_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            if (r_state == FSM_LOOKUP || (r_state == FSM_BUS && bus_ack)) r_err <= w_err;
            else if (r_state == FSM_CLEAR) r_err <= 1'b0;
            if (r_state == FSM_UPDATE && r_err) begin
                err_sticky <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mesi_line_ctrl.md
# mesi_line_ctrl

Sequential MESI coherence controller for the L2 data cache: holds the MESI state of every line (NUM_SETS × NUM_WAYS) and processes one L1/snoop command at a time through a valid/ready handshake. Issues bus operations for misses and upgrades, returns the snoop result to drive, and flags writebacks. Sits between the L2 tag/hit logic, which supplies set and way, and the bus interface unit.

## Interface
- NUM_SETS, 16: sets tracked; power of two, ≥2; SET_W = clog2(NUM_SETS)
- NUM_WAYS, 4: ways per set; power of two, ≥1; WAY_W = max(1, clog2(NUM_WAYS))
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_op  in  4  0 L1 read, 1 L1 write, 2 L1 instr read, 3 snoop invalidate, 4 snoop read, 5 snoop write, 6 snoop RFO, 8 clear, 9 print
- cmd_set / cmd_way  in  SET_W / WAY_W  addressed line
- bus_req_valid  out  1  bus operation request
- bus_req_op  out  2  0 READ, 1 RFO, 2 INVALIDATE
- bus_ack  in  1  bus op complete
- bus_snoop_res  in  2  result returned with bus_ack: NoHIT 00, HIT 01, HITM 10
- rsp_valid  out  1  one-cycle completion pulse
- rsp_prev_state / rsp_next_state  out  2 / 2  M 00, E 01, S 10, I 11
- rsp_snoop_out  out  2  result this cache drives for snoops, NoHIT/HIT/HITM
- rsp_writeback  out  1  line was Modified and must be written back
- busy  out  1  high whenever not IDLE

## Operation
- FSM: IDLE → LOOKUP → (BUS) → UPDATE → IDLE; IDLE → CLEAR → UPDATE for op 8.
- IDLE: cmd_ready=1; accept registers op/set/way.
- LOOKUP: read current state of the addressed line; decide bus op via transition rules.
- BUS: bus_req_valid held with stable bus_req_op until bus_ack; bus_snoop_res sampled on the ack cycle.
- UPDATE: write next state, pulse rsp_valid with all rsp_* fields.
- Transitions (reads = ops 0, 2):
- M: reads/write → M; snoop read → S, HITM, writeback; RFO → I, HITM, writeback; snoop write/invalidate → stay M (protocol error).
- E: reads → E; write → M; snoop read → S, HIT; RFO → I, HIT; snoop write/invalidate → stay E (error).
- S: reads → S; write → bus INVALIDATE then M; snoop read → S, HIT; snoop invalidate/RFO → I, HIT; snoop write → stay S (error).
- I: reads → bus READ, then S if HIT/HITM else E; write → bus RFO then M; all snoops → I, NoHIT.
- rsp_snoop_out = NoHIT for L1 ops; rsp_writeback = 0 except where stated.
- Op 9: no state change, rsp_prev = rsp_next = current state. Ops 7, 10–15: no change, rsp_prev = rsp_next = current state (error when enabled).
- CLEAR: sweep counter writes all ways of one set to I per cycle, set 0 upward; rsp_prev = rsp_next = I.

## Timing
- Reset: all lines I; FSM IDLE; cmd_ready=1; bus_req_valid, rsp_valid, rsp_writeback, busy = 0; rsp_* states = I (11); rsp_snoop_out = 00.
- No-bus command accepted in cycle 0 → rsp_valid in cycle 2.
- Bus command: bus_req_valid from cycle 2; ack in cycle k → rsp_valid in cycle k+1; ack in cycle 2 is legal.
- bus_ack outside BUS is ignored.
- Clear: rsp_valid NUM_SETS+1 cycles after accept.
- The array write and rsp_valid occur in the same cycle; a command accepted the next cycle sees the new state.
- Reset mid-operation aborts immediately; no response is produced; bus_req_valid drops asynchronously.

## Configuration
- MESI_PROTOCOL_ERR_EN defined: adds outputs err_sticky (1b, set on protocol error or illegal opcode in UPDATE, cleared only by reset) and err_count (8b, saturating at 255); reset 0.
- Undefined: error cases are silently no-ops, with identical state and response behaviour; the ports are absent.

## Structure
- mesi_pkg: state encodings, snoop-result encodings, cmd opcodes, bus op codes, FSM state enum.
- Sub-module mesi_next_state: combinational (state, op, bus_snoop_res) → next state, snoop out, writeback, bus op, error; the FSM instantiates it once.

## Test plan
- Set 3 way 1 in I, L1 read, ack with NoHIT → bus READ; rsp prev=11, next=01.
- Same line, L1 write → no bus; next=00; then snoop read → next=10, snoop_out=10, writeback=1.
- Shared line, L1 write → bus INVALIDATE held 5 cycles until ack; next=00; rsp 1 cycle after ack.
- Exclusive line, snoop write → state stays 01; with macro, err_sticky=1 and err_count=1.
- Fill several lines, clear → rsp_valid exactly NUM_SETS+1 cycles after accept; print each line → 11.
- Assert rst_n during BUS → outputs at reset values; re-read line → prior state unchanged by aborted op, or I if reset.
